fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/pc_reg.sv | 39 +++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: word type, NOP/halt encodings, PC select.
package fetch_stage_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t      NOP        = 32'h0000_0000;
  localparam logic [5:0] HALT_OP    = 6'b111111;
  localparam logic [5:0] HALT_FUNCT = 6'b111111;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

  function automatic logic is_halt_instr(input word_t instr);
    return (instr[31:26] == HALT_OP) && (instr[5:0] == HALT_FUNCT);
  endfunction

  // Instruction addresses are word aligned; low two bits of any target are dropped.
  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Decode-side control and instruction-memory bus seen by the fetch stage.
import fetch_stage_pkg::*;

interface fetch_stage_if;
  logic       stall;
  logic       branch_taken;
  word_t      branch_target;
  logic       jump_taken;
  word_t      jump_target;
  logic       terminate;
  word_t      imem_addr;
  word_t      imem_data;
  word_t      instr_d;
  logic [5:0] op_d;
  logic [5:0] funct_d;
  word_t      pc_plus4_d;
  logic       valid_d;
  logic       halted;

  modport master (
    input  stall, branch_taken, branch_target, jump_taken, jump_target,
           terminate, imem_data,
    output imem_addr, instr_d, op_d, funct_d, pc_plus4_d, valid_d, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, jump_taken, jump_target,
           terminate, imem_data,
    input  imem_addr, instr_d, op_d, funct_d, pc_plus4_d, valid_d, halted
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter with load enable and next-value select (sequential / jump / branch).
import fetch_stage_pkg::*;

module pc_reg #(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load_en_i,
  input  pc_sel_e sel_i,
  input  word_t   jump_target_i,
  input  word_t   branch_target_i,
  output word_t   pc_o,
  output word_t   pc_plus4_o
);

  word_t pc_q, pc_d;

  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  always_comb begin
    pc_d = pc_plus4_o;
    case (sel_i)
      PC_JUMP:   pc_d = align_word(jump_target_i);
      PC_BRANCH: pc_d = align_word(branch_target_i);
      default:   pc_d = pc_plus4_o;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_en_i) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and RUN/DRAIN/HALT control.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter word_t RESET_PC     = 32'h0000_0000,
  parameter int    DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  fetch_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q;
  word_t            instr_q;
  word_t            pc_plus4_q;
  logic             valid_q;

  word_t   pc;
  word_t   pc_plus4;
  logic    pc_load;
  pc_sel_e pc_sel;
  logic    take_term;
  logic    take_redirect;

  // Redirects and terminate only count when the IF/ID slot carries a real
  // instruction; a stall freezes everything and masks redirects.
  always_comb begin
    take_term     = 1'b0;
    take_redirect = 1'b0;
    pc_load       = 1'b0;
    pc_sel        = PC_SEQ;
    if (state_q == ST_RUN) begin
      take_term = valid_q && bus.terminate;
      if (!take_term && !bus.stall) begin
        pc_load       = 1'b1;
        take_redirect = valid_q && (bus.jump_taken || bus.branch_taken);
        if (valid_q && bus.jump_taken) begin
          pc_sel = PC_JUMP;
        end else if (valid_q && bus.branch_taken) begin
          pc_sel = PC_BRANCH;
        end
      end
    end
  end

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .load_en_i      (pc_load),
    .sel_i          (pc_sel),
    .jump_target_i  (bus.jump_target),
    .branch_target_i(bus.branch_target),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      instr_q    <= NOP;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (take_term) begin
            state_q    <= ST_DRAIN;
            cnt_q      <= '0;
            instr_q    <= NOP;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
          end else if (!bus.stall) begin
            if (take_redirect) begin
              instr_q    <= NOP;
              pc_plus4_q <= '0;
              valid_q    <= 1'b0;
            end else begin
              instr_q    <= bus.imem_data;
              pc_plus4_q <= pc_plus4;
              valid_q    <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.instr_d    = instr_q;
  assign bus.op_d       = instr_q[31:26];
  assign bus.funct_d    = instr_q[5:0];
  assign bus.pc_plus4_d = pc_plus4_q;
  assign bus.valid_d    = valid_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against a cycle-level model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t RST_PC   = 32'h0000_0000;
  localparam int    DRAIN    = 4;
  localparam word_t IMEM_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus ();
  assign bus.imem_data = bus.imem_addr ^ IMEM_KEY;

  fetch_stage #(
    .RESET_PC    (RST_PC),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Model state: architectural PC, IF/ID contents, and cycles since terminate (-1 = running).
  word_t m_pc, m_instr, m_pp4;
  bit    m_valid, m_halted;
  int    m_since;

  task automatic model_step(input bit r, input bit s, input bit bt, input word_t btgt,
                            input bit jt, input word_t jtgt, input bit tm);
    if (r) begin
      m_pc = RST_PC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_since = -1; m_halted = 0;
    end else if (m_since >= 0) begin
      m_since++;
      m_halted = (m_since >= DRAIN);
    end else if (tm && m_valid) begin
      m_since = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (s) begin
      // everything holds
    end else if (jt && m_valid) begin
      m_pc = {jtgt[31:2], 2'b00}; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (bt && m_valid) begin
      m_pc = {btgt[31:2], 2'b00}; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else begin
      m_instr = m_pc ^ IMEM_KEY;
      m_pp4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("imem_addr", bus.imem_addr, m_pc);
    check_eq("instr_d", bus.instr_d, m_instr);
    check_eq("op_d", word_t'(bus.op_d), word_t'(m_instr[31:26]));
    check_eq("funct_d", word_t'(bus.funct_d), word_t'(m_instr[5:0]));
    check_eq("pc_plus4_d", bus.pc_plus4_d, m_pp4);
    check_eq("valid_d", word_t'(bus.valid_d), word_t'(m_valid));
    check_eq("halted", word_t'(bus.halted), word_t'(m_halted));
  endtask

  // Called at a falling edge: drive, advance model, clock, then compare at the next falling edge.
  task automatic cycle(input bit r, input bit s, input bit bt, input word_t btgt,
                       input bit jt, input word_t jtgt, input bit tm);
    rst = r;
    bus.stall = s;
    bus.branch_taken = bt;
    bus.branch_target = btgt;
    bus.jump_taken = jt;
    bus.jump_target = jtgt;
    bus.terminate = tm;
    model_step(r, s, bt, btgt, jt, jtgt, tm);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump_taken = 0; bus.jump_target = 0; bus.terminate = 0;
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0; m_since = -1;
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_valid", word_t'(bus.valid_d), 32'h0);
    check_eq("rst_halted", word_t'(bus.halted), 32'h0);
    check_eq("rst_instr", bus.instr_d, 32'h0);

    // Sequential fetch from reset
    idle();
    check_eq("seq0_instr", bus.instr_d, 32'hA5A5_0000);
    check_eq("seq0_pp4", bus.pc_plus4_d, 32'h4);
    check_eq("seq0_valid", word_t'(bus.valid_d), 32'h1);
    idle();
    check_eq("seq1_addr", bus.imem_addr, 32'h8);

    // Stall two cycles at PC 8
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 1, 32'h300, 0, 0, 0);
      check_eq("stall_addr", bus.imem_addr, 32'h8);
      check_eq("stall_pp4", bus.pc_plus4_d, 32'h8);
    end
    idle();
    check_eq("resume_addr", bus.imem_addr, 32'hC);

    // Branch with unaligned target
    cycle(0, 0, 1, 32'h0000_0043, 0, 0, 0);
    check_eq("br_addr", bus.imem_addr, 32'h40);
    check_eq("br_valid", word_t'(bus.valid_d), 32'h0);
    idle();
    check_eq("br_instr", bus.instr_d, 32'h40 ^ IMEM_KEY);

    // Jump beats branch; stall beats both
    cycle(0, 0, 1, 32'h200, 1, 32'h100, 0);
    check_eq("jb_addr", bus.imem_addr, 32'h100);
    idle();
    check_eq("jb_next", bus.imem_addr, 32'h104);
    cycle(0, 1, 1, 32'h200, 1, 32'h100, 0);
    check_eq("sj_addr", bus.imem_addr, 32'h104);
    check_eq("sj_valid", word_t'(bus.valid_d), 32'h1);

    // Terminate and drain; redirects during drain are ignored
    cycle(0, 0, 0, 0, 0, 0, 1);
    check_eq("term_addr", bus.imem_addr, 32'h104);
    check_eq("term_valid", word_t'(bus.valid_d), 32'h0);
    for (int i = 1; i < DRAIN; i++) begin
      cycle(0, 0, 1, 32'h500, 1, 32'h600, 1);
      check_eq("drain_halted", word_t'(bus.halted), 32'h0);
    end
    idle();
    check_eq("halt_now", word_t'(bus.halted), 32'h1);
    check_eq("halt_addr", bus.imem_addr, 32'h104);

    // Reset in the middle of draining
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle();
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("midrst_halted", word_t'(bus.halted), 32'h0);
    check_eq("midrst_addr", bus.imem_addr, RST_PC);

    // PC wrap at the top of the address space
    idle();
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    check_eq("wrap_pre", bus.imem_addr, 32'hFFFF_FFFC);
    idle();
    check_eq("wrap_addr", bus.imem_addr, 32'h0);
    check_eq("wrap_pp4", bus.pc_plus4_d, 32'h0);
    check_eq("wrap_instr", bus.instr_d, 32'hFFFF_FFFC ^ IMEM_KEY);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 79) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
